// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational ALU between two requesters, with multicycle holds for MUL/DIV.
// Optional feature: define ALU_SCHED_DIV0_FLAG_EN to add res_err and a fast divide-by-zero/reserved-op path.
module alu_sched #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [7:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_src
`ifdef ALU_SCHED_DIV0_FLAG_EN
    ,
    output logic        res_err
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_RSV = 3'd7;

`ifdef ALU_SCHED_DIV0_FLAG_EN
    localparam logic DIV0_SKIP = 1'b1;
`else
    localparam logic DIV0_SKIP = 1'b0;
`endif

    state_t      state_q, state_d;
    logic        last_grant;
    logic [3:0]  cnt;
    logic        div0_q;

    logic        grant;
    logic [2:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_div0;
    logic        skip_exec;
    logic        accept;
    logic        capture;
    logic        release_res;

    function automatic logic [3:0] hold_minus_one(input logic [2:0] op);
        case (op)
            OP_MUL:  return 4'(MUL_CYCLES - 1);
            OP_DIV:  return 4'(DIV_CYCLES - 1);
            default: return 4'd0;
        endcase
    endfunction

    // On a tie the requester that did not win last time gets the ALU.
    assign grant     = (req0_valid && req1_valid) ? !last_grant : req1_valid;
    assign sel_op    = grant ? req1_op : req0_op;
    assign sel_a     = grant ? req1_a  : req0_a;
    assign sel_b     = grant ? req1_b  : req0_b;
    assign sel_div0  = (sel_op == OP_DIV) && (sel_b == 32'd0);
    assign skip_exec = (sel_op == OP_RSV) || (DIV0_SKIP && sel_div0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = !grant;
                    req1_ready = grant;
                    state_d    = skip_exec ? DONE : EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU inputs are frozen from accept until the result handshake so MUL/DIV can be multicycle paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1    <= 32'd0;
            alu_in2    <= 32'd0;
            alu_ctrl   <= 8'hFF;
            res_data   <= 32'd0;
            res_valid  <= 1'b0;
            res_src    <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            div0_q     <= 1'b0;
        end else begin
            if (accept) begin
                alu_in1    <= sel_a;
                alu_in2    <= sel_b;
                alu_ctrl   <= {5'd0, sel_op};
                res_src    <= grant;
                last_grant <= grant;
                cnt        <= hold_minus_one(sel_op);
                div0_q     <= sel_div0;
                if (skip_exec) begin
                    res_valid <= 1'b1;
                    res_data  <= (sel_op == OP_RSV) ? 32'd0 : 32'hFFFF_FFFF;
                end
            end
            if (state_q == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= div0_q ? 32'hFFFF_FFFF : alu_result;
            end
            if (release_res) begin
                res_valid <= 1'b0;
                alu_ctrl  <= 8'hFF;
            end
        end
    end

`ifdef ALU_SCHED_DIV0_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err <= 1'b0;
        end else if (accept) begin
            res_err <= (sel_op == OP_RSV) || sel_div0;
        end else if (release_res) begin
            res_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_alu_sched;

    localparam int MUL_CYCLES = 2;
    localparam int DIV_CYCLES = 4;
`ifdef ALU_SCHED_DIV0_FLAG_EN
    localparam bit FLAG_EN = 1'b1;
`else
    localparam bit FLAG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] alu_in1, alu_in2, alu_result;
    logic [7:0]  alu_ctrl;
    logic        res_valid, res_ready, res_src;
    logic [31:0] res_data;
`ifdef ALU_SCHED_DIV0_FLAG_EN
    logic        res_err;
`endif

    int checks = 0;
    int errors = 0;

    alu_sched #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_src(res_src)
`ifdef ALU_SCHED_DIV0_FLAG_EN
        , .res_err(res_err)
`endif
    );

    always #5 clk = ~clk;

    // Environment ALU; divide-by-zero returns junk that the scheduler must ignore.
    always_comb begin
        case (alu_ctrl)
            8'd0:    alu_result = alu_in1 + alu_in2;
            8'd1:    alu_result = alu_in1 - alu_in2;
            8'd2:    alu_result = alu_in1 * alu_in2;
            8'd3:    alu_result = (alu_in2 == 32'd0) ? 32'h0BAD_0BAD : alu_in1 / alu_in2;
            8'd4:    alu_result = alu_in1 ^ alu_in2;
            8'd5:    alu_result = alu_in1 & alu_in2;
            8'd6:    alu_result = alu_in1 | alu_in2;
            default: alu_result = 32'd0;
        endcase
    end

    function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd4:    return a ^ b;
            3'd5:    return a & b;
            3'd6:    return a | b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] op, input logic [31:0] b);
        if (op == 3'd7) return 0;
        if (op == 3'd3 && b == 32'd0 && FLAG_EN) return 0;
        if (op == 3'd2) return MUL_CYCLES;
        if (op == 3'd3) return DIV_CYCLES;
        return 1;
    endfunction

    // Reference model: one transaction in flight, result visible after a fixed number of edges.
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    bit          m_last = 1'b1;
    bit          m_src = 1'b0;
    bit          m_err = 1'b0;
    logic [2:0]  m_op = 3'd0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0, m_data = 32'd0;

    wire         m_pick = (req0_valid && req1_valid) ? !m_last : req1_valid;
    wire [2:0]   p_op   = m_pick ? req1_op : req0_op;
    wire [31:0]  p_a    = m_pick ? req1_a  : req0_a;
    wire [31:0]  p_b    = m_pick ? req1_b  : req0_b;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_wait <= 0;
            m_last <= 1'b1;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                m_busy <= 1'b1;
                m_last <= m_pick;
                m_src  <= m_pick;
                m_op   <= p_op;
                m_a    <= p_a;
                m_b    <= p_b;
                m_data <= refResult(p_op, p_a, p_b);
                m_wait <= refLatency(p_op, p_b);
                m_err  <= (p_op == 3'd7) || (p_op == 3'd3 && p_b == 32'd0);
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
        end else if (res_ready) begin
            m_busy <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
            checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
            checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
            checkOutput("rst_alu_ctrl", 32'(alu_ctrl), 32'hFF);
            checkOutput("rst_alu_in1", alu_in1, 32'd0);
            checkOutput("rst_alu_in2", alu_in2, 32'd0);
            checkOutput("rst_res_data", res_data, 32'd0);
            checkOutput("rst_res_src", 32'(res_src), 32'd0);
`ifdef ALU_SCHED_DIV0_FLAG_EN
            checkOutput("rst_res_err", 32'(res_err), 32'd0);
`endif
        end else begin
            checkOutput("model_req0_ready", 32'(req0_ready),
                        32'(!m_busy && req0_valid && (!req1_valid || m_last)));
            checkOutput("model_req1_ready", 32'(req1_ready),
                        32'(!m_busy && req1_valid && (!req0_valid || !m_last)));
            checkOutput("model_res_valid", 32'(res_valid), 32'(m_busy && (m_wait == 0)));
            if (m_busy) begin
                checkOutput("model_alu_ctrl", 32'(alu_ctrl), 32'(m_op));
                checkOutput("model_alu_in1", alu_in1, m_a);
                checkOutput("model_alu_in2", alu_in2, m_b);
                if (m_wait == 0) begin
                    checkOutput("model_res_data", res_data, m_data);
                    checkOutput("model_res_src", 32'(res_src), 32'(m_src));
`ifdef ALU_SCHED_DIV0_FLAG_EN
                    checkOutput("model_res_err", 32'(res_err), 32'(m_err));
`endif
                end
            end else begin
                checkOutput("model_idle_alu_ctrl", 32'(alu_ctrl), 32'hFF);
            end
        end
    end

    task automatic applyStimulus(input bit port, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (port) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic waitAccept(input bit port);
        bit got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout: got no ready on port %0d, required ready", port);
        end
        @(posedge clk);
        #1;
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic waitResult(input string name, input logic [31:0] exp_data, input bit exp_src, input int exp_lat,
                              input logic [7:0] exp_ctrl, input logic [31:0] exp_a, input logic [31:0] exp_b,
                              input int bp);
        bit seen = 1'b0;
        int lat = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1'b1;
                lat = k;
            end else begin
                checkOutput({name, "_exec_ctrl"}, 32'(alu_ctrl), 32'(exp_ctrl));
                checkOutput({name, "_exec_in1"}, alu_in1, exp_a);
                checkOutput({name, "_exec_in2"}, alu_in2, exp_b);
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL %s_timeout: got no res_valid, required res_valid", name);
            return;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, "_data"}, res_data, exp_data);
        checkOutput({name, "_src"}, 32'(res_src), 32'(exp_src));
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            checkOutput({name, "_bp_valid"}, 32'(res_valid), 32'd1);
            checkOutput({name, "_bp_data"}, res_data, exp_data);
            checkOutput({name, "_bp_req1_ready"}, 32'(req1_ready), 32'd0);
        end
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = 32'd0; req1_b = 32'd0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(0, 3'd0, 32'd5, 32'd7);
        waitAccept(0);
        waitResult("add", 32'd12, 1'b0, 1, 8'h00, 32'd5, 32'd7, 0);
        checkOutput("add_ctrl_after_handshake", 32'(alu_ctrl), 32'hFF);

        doReset();
        applyStimulus(0, 3'd4, 32'hF0F0_0000, 32'h0FF0_0000);
        applyStimulus(1, 3'd5, 32'h0000_00FF, 32'h0000_000F);
        #3;
        checkOutput("tie1_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("tie1_req1_ready", 32'(req1_ready), 32'd0);
        waitAccept(0);
        waitResult("xor", 32'hFF00_0000, 1'b0, 1, 8'h04, 32'hF0F0_0000, 32'h0FF0_0000, 0);
        waitAccept(1);
        waitResult("and", 32'h0000_000F, 1'b1, 1, 8'h05, 32'h0000_00FF, 32'h0000_000F, 0);
        applyStimulus(0, 3'd0, 32'd1, 32'd1);
        applyStimulus(1, 3'd0, 32'd2, 32'd2);
        #3;
        checkOutput("tie2_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("tie2_req1_ready", 32'(req1_ready), 32'd0);
        waitAccept(0);
        waitResult("tie2_first", 32'd2, 1'b0, 1, 8'h00, 32'd1, 32'd1, 0);
        waitAccept(1);
        waitResult("tie2_second", 32'd4, 1'b1, 1, 8'h00, 32'd2, 32'd2, 0);

        applyStimulus(0, 3'd2, 32'd3, 32'd4);
        waitAccept(0);
        waitResult("mul", 32'd12, 1'b0, 2, 8'h02, 32'd3, 32'd4, 0);
        applyStimulus(1, 3'd3, 32'd100, 32'd7);
        waitAccept(1);
        waitResult("div", 32'd14, 1'b1, 4, 8'h03, 32'd100, 32'd7, 0);

        applyStimulus(0, 3'd1, 32'd3, 32'd5);
        waitAccept(0);
        applyStimulus(1, 3'd0, 32'd10, 32'd20);
        waitResult("sub_bp", 32'hFFFF_FFFE, 1'b0, 1, 8'h01, 32'd3, 32'd5, 5);
        waitAccept(1);
        waitResult("after_bp", 32'd30, 1'b1, 1, 8'h00, 32'd10, 32'd20, 0);

        applyStimulus(0, 3'd3, 32'd9, 32'd0);
        waitAccept(0);
`ifdef ALU_SCHED_DIV0_FLAG_EN
        #3 checkOutput("div0_err", 32'(res_err), 32'd1);
`endif
        waitResult("div0", 32'hFFFF_FFFF, 1'b0, FLAG_EN ? 0 : DIV_CYCLES, 8'h03, 32'd9, 32'd0, 0);
        applyStimulus(1, 3'd7, 32'd1, 32'd2);
        waitAccept(1);
        waitResult("rsv", 32'd0, 1'b1, 0, 8'h07, 32'd1, 32'd2, 0);

        applyStimulus(0, 3'd3, 32'd100, 32'd7);
        waitAccept(0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("midrst_alu_ctrl", 32'(alu_ctrl), 32'hFF);
        checkOutput("midrst_alu_in1", alu_in1, 32'd0);
        checkOutput("midrst_res_data", res_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("midrst_no_result", 32'(res_valid), 32'd0);
        end

        fork
            for (int c = 0; c < 3000; c++) begin
                bit acc;
                @(negedge clk);
                acc = req0_valid && req0_ready;
                @(posedge clk);
                #1;
                if (acc || !req0_valid) begin
                    if ($urandom_range(0, 2) == 0) begin
                        applyStimulus(0, 3'($urandom_range(0, 7)),
                                      ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom(),
                                      ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom());
                    end else begin
                        req0_valid = 1'b0;
                    end
                end
            end
            for (int c = 0; c < 3000; c++) begin
                bit acc;
                @(negedge clk);
                acc = req1_valid && req1_ready;
                @(posedge clk);
                #1;
                if (acc || !req1_valid) begin
                    if ($urandom_range(0, 2) == 0) begin
                        applyStimulus(1, 3'($urandom_range(0, 7)),
                                      ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom(),
                                      ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom());
                    end else begin
                        req1_valid = 1'b0;
                    end
                end
            end
            for (int c = 0; c < 3000; c++) begin
                @(posedge clk);
                #1 res_ready = 1'($urandom_range(0, 1));
            end
        join

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        repeat (40) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
